// File: rtl/cam_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : cam_pattern_gen
// Brief   : OV7670-style camera source with programmable frame timing and
//           selectable RGB444 test patterns plus a pixel side channel.
// Revision: 1.0 - initial release
// ============================================================================
module cam_pattern_gen #(
    parameter int          HACTIVE     = 640,
    parameter int          VACTIVE     = 480,
    parameter int          VSYNC_CLKS  = 4704,
    parameter int          VBP_CLKS    = 26656,
    parameter int          HBLANK_CLKS = 288,
    parameter int          VFP_CLKS    = 7840,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter logic [11:0] SOLID_RGB   = 12'h5A3
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_en,
    input  logic [1:0]  i_mode,
    output logic        o_vsync,
    output logic        o_href,
    output logic [7:0]  o_data,
    output logic [11:0] o_pixel,
    output logic        o_pixel_valid,
    output logic        o_frame_done,
    output logic        o_busy
);

    localparam int LINE_BYTES = 2 * HACTIVE;
    localparam int BAR_PIX    = HACTIVE / 8;
    localparam int MAX_A      = (VSYNC_CLKS > VBP_CLKS) ? VSYNC_CLKS : VBP_CLKS;
    localparam int MAX_B      = (LINE_BYTES > HBLANK_CLKS) ? LINE_BYTES : HBLANK_CLKS;
    localparam int MAX_AB     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_ALL    = (MAX_AB > VFP_CLKS) ? MAX_AB : VFP_CLKS;
    localparam int CNT_W      = $clog2(MAX_ALL + 1);
    localparam int LINE_W     = (VACTIVE > 1) ? $clog2(VACTIVE) : 1;
    localparam int SUB_W      = (BAR_PIX > 1) ? $clog2(BAR_PIX) : 1;

    localparam logic [CNT_W-1:0]  VSYNC_LOAD  = CNT_W'(VSYNC_CLKS - 1);
    localparam logic [CNT_W-1:0]  VBP_LOAD    = CNT_W'(VBP_CLKS - 1);
    localparam logic [CNT_W-1:0]  LINE_LOAD   = CNT_W'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0]  HBLANK_LOAD = CNT_W'(HBLANK_CLKS - 1);
    localparam logic [CNT_W-1:0]  VFP_LOAD    = CNT_W'(VFP_CLKS - 1);
    localparam logic [LINE_W-1:0] LINE_LAST   = LINE_W'(VACTIVE - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST    = SUB_W'(BAR_PIX - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBP    = 3'd2,
        S_LINE   = 3'd3,
        S_HBLANK = 3'd4,
        S_VFP    = 3'd5
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [LINE_W-1:0]  line, line_n;
    logic [1:0]         mode, mode_n;
    logic               phase, phase_n;
    logic               pat_reset;
    logic               emit;
    logic               advance;

    logic [11:0]        pix_cnt, pix_cnt_n;
    logic [15:0]        lfsr, lfsr_n;
    logic               lfsr_fb;
    logic [2:0]         bar, bar_n;
    logic [SUB_W-1:0]   sub, sub_n;
    logic [11:0]        bar_rgb;
    logic [11:0]        pix;

    logic               vsync_q, vsync_n;
    logic               href_q, href_n;
    logic [7:0]         data_q, data_n;
    logic [11:0]        pixel_q, pixel_n;
    logic               pvalid_q, pvalid_n;
    logic               fdone_q, fdone_n;
    logic               busy_q, busy_n;

    // ------------------------------------------------------------------------
    // Frame sequencer: every state is timed by the shared down-counter
    // ------------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        cnt_n     = cnt - 1'b1;
        line_n    = line;
        mode_n    = mode;
        pat_reset = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_n = cnt;
                if (i_en) begin
                    state_n   = S_VSYNC;
                    cnt_n     = VSYNC_LOAD;
                    mode_n    = i_mode;
                    line_n    = '0;
                    pat_reset = 1'b1;
                end
            end
            S_VSYNC: begin
                if (cnt == '0) begin
                    state_n = S_VBP;
                    cnt_n   = VBP_LOAD;
                end
            end
            S_VBP: begin
                if (cnt == '0) begin
                    state_n = S_LINE;
                    cnt_n   = LINE_LOAD;
                end
            end
            S_LINE: begin
                if (cnt == '0) begin
                    state_n = S_HBLANK;
                    cnt_n   = HBLANK_LOAD;
                end
            end
            S_HBLANK: begin
                if (cnt == '0) begin
                    if (line == LINE_LAST) begin
                        state_n = S_VFP;
                        cnt_n   = VFP_LOAD;
                    end else begin
                        state_n = S_LINE;
                        cnt_n   = LINE_LOAD;
                        line_n  = line + 1'b1;
                    end
                end
            end
            S_VFP: begin
                if (cnt == '0) begin
                    // Back-to-back frames skip IDLE entirely
                    if (i_en) begin
                        state_n   = S_VSYNC;
                        cnt_n     = VSYNC_LOAD;
                        mode_n    = i_mode;
                        line_n    = '0;
                        pat_reset = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pattern sources
    // ------------------------------------------------------------------------
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_comb begin
        bar_rgb = 12'h000;
        case (bar)
            3'd0:    bar_rgb = 12'hFFF;
            3'd1:    bar_rgb = 12'hFF0;
            3'd2:    bar_rgb = 12'h0FF;
            3'd3:    bar_rgb = 12'h0F0;
            3'd4:    bar_rgb = 12'hF0F;
            3'd5:    bar_rgb = 12'hF00;
            3'd6:    bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
    end

    always_comb begin
        pix = pix_cnt;
        case (mode)
            2'd0:    pix = pix_cnt;
            2'd1:    pix = bar_rgb;
            2'd2:    pix = lfsr[11:0];
            default: pix = SOLID_RGB;
        endcase
    end

    // All pattern generators step together after each odd byte. The bar
    // index holds exactly eight bars per line, so it wraps to 0 at line end.
    always_comb begin
        pix_cnt_n = pix_cnt;
        lfsr_n    = lfsr;
        bar_n     = bar;
        sub_n     = sub;
        if (pat_reset) begin
            pix_cnt_n = 12'h000;
            lfsr_n    = LFSR_SEED;
            bar_n     = 3'd0;
            sub_n     = '0;
        end else if (advance) begin
            pix_cnt_n = pix_cnt + 12'd1;
            lfsr_n    = {lfsr[14:0], lfsr_fb};
            if (sub == SUB_LAST) begin
                sub_n = '0;
                bar_n = bar + 3'd1;
            end else begin
                sub_n = sub + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output decode, based on the state being entered so outputs register
    // in lock-step with the state register
    // ------------------------------------------------------------------------
    always_comb begin
        emit     = (state_n == S_LINE);
        advance  = emit & phase;
        phase_n  = emit & ~phase;
        vsync_n  = (state_n == S_VSYNC);
        href_n   = emit;
        data_n   = 8'h00;
        pixel_n  = pixel_q;
        pvalid_n = 1'b0;
        fdone_n  = (state_n == S_VFP) && (cnt_n == '0);
        busy_n   = (state_n != S_IDLE);
        if (emit) begin
            if (phase) begin
                data_n   = pix[7:0];
                pixel_n  = pix;
                pvalid_n = 1'b1;
            end else begin
                data_n   = {4'hF, pix[11:8]};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            line     <= '0;
            mode     <= 2'd0;
            phase    <= 1'b0;
            pix_cnt  <= 12'h000;
            lfsr     <= LFSR_SEED;
            bar      <= 3'd0;
            sub      <= '0;
            vsync_q  <= 1'b0;
            href_q   <= 1'b0;
            data_q   <= 8'h00;
            pixel_q  <= 12'h000;
            pvalid_q <= 1'b0;
            fdone_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            line     <= line_n;
            mode     <= mode_n;
            phase    <= phase_n;
            pix_cnt  <= pix_cnt_n;
            lfsr     <= lfsr_n;
            bar      <= bar_n;
            sub      <= sub_n;
            vsync_q  <= vsync_n;
            href_q   <= href_n;
            data_q   <= data_n;
            pixel_q  <= pixel_n;
            pvalid_q <= pvalid_n;
            fdone_q  <= fdone_n;
            busy_q   <= busy_n;
        end
    end

    assign o_vsync       = vsync_q;
    assign o_href        = href_q;
    assign o_data        = data_q;
    assign o_pixel       = pixel_q;
    assign o_pixel_valid = pvalid_q;
    assign o_frame_done  = fdone_q;
    assign o_busy        = busy_q;

endmodule
`default_nettype wire
